sti_dac_pixel_ctrl: RTL and testbench

Write-port controller for the 256x8 pixel memory downstream of the STI serial transmitter. Deserialises the MSB-first so_data/so_valid stream into bytes and issues one write per byte at a linearly incrementing address. When the stream ends it zero-fills the rest of the memory and then raises pixel_finish.

---
 rtl/sti_dac_pixel_ctrl.sv | 105 ++++++++++
 tb/tb_sti_dac_pixel_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sti_dac_pixel_ctrl.sv
// sti_dac_pixel_ctrl: turns the MSB-first serial pixel stream into byte writes to a 256x8 memory,
// then zero-fills the remaining addresses. Optional macro PARTIAL_FLUSH_EN writes out a trailing partial byte.
`default_nettype none

module sti_dac_pixel_ctrl #(
    parameter logic [7:0] FILL_VALUE = 8'h00,
    parameter int         LAST_ADDR  = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       so_data,
    input  logic       so_valid,
    input  logic       pi_end,
    output logic       pixel_wr,
    output logic [7:0] pixel_addr,
    output logic [7:0] pixel_dataout,
    output logic       pixel_finish
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FILL    = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [8:0] LAST = 9'(LAST_ADDR);

    state_t     state;
    logic [7:0] shift_reg;
    logic [2:0] bit_cnt;
    logic [8:0] addr_cnt;
    logic [7:0] next_byte;

    assign next_byte = {shift_reg[6:0], so_data};

`ifdef PARTIAL_FLUSH_EN
    // Newest bits sit in the LSBs; shifting left drops stale bits of the previous byte.
    logic [7:0] partial_byte;
    assign partial_byte = shift_reg << (4'd8 - {1'b0, bit_cnt});
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            shift_reg     <= 8'd0;
            bit_cnt       <= 3'd0;
            addr_cnt      <= 9'd0;
            pixel_wr      <= 1'b0;
            pixel_addr    <= 8'd0;
            pixel_dataout <= 8'd0;
            pixel_finish  <= 1'b0;
        end else begin
            pixel_wr <= 1'b0;
            case (state)
                IDLE, COLLECT: begin
                    if (so_valid) begin
                        shift_reg <= next_byte;
                        bit_cnt   <= bit_cnt + 3'd1;
                        state     <= COLLECT;
                        if (bit_cnt == 3'd7) begin
                            pixel_wr      <= 1'b1;
                            pixel_addr    <= addr_cnt[7:0];
                            pixel_dataout <= next_byte;
                            addr_cnt      <= addr_cnt + 9'd1;
                            if (addr_cnt == LAST)
                                state <= DONE;
                        end
                    end else if (pi_end) begin
                        shift_reg <= 8'd0;
                        bit_cnt   <= 3'd0;
                        state     <= FILL;
`ifdef PARTIAL_FLUSH_EN
                        if (bit_cnt != 3'd0) begin
                            pixel_wr      <= 1'b1;
                            pixel_addr    <= addr_cnt[7:0];
                            pixel_dataout <= partial_byte;
                            addr_cnt      <= addr_cnt + 9'd1;
                        end
`endif
                    end
                end
                FILL: begin
                    // Counter one past the last address means every location is written.
                    if (addr_cnt > LAST) begin
                        state        <= DONE;
                        pixel_finish <= 1'b1;
                    end else begin
                        pixel_wr      <= 1'b1;
                        pixel_addr    <= addr_cnt[7:0];
                        pixel_dataout <= FILL_VALUE;
                        addr_cnt      <= addr_cnt + 9'd1;
                    end
                end
                DONE: begin
                    pixel_finish <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sti_dac_pixel_ctrl.sv
// tb_sti_dac_pixel_ctrl: scoreboard bench for sti_dac_pixel_ctrl (expected writes queued at stimulus time).
`default_nettype none

module tb_sti_dac_pixel_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       so_data = 1'b0;
    logic       so_valid = 1'b0;
    logic       pi_end = 1'b0;
    logic       pixel_wr;
    logic [7:0] pixel_addr;
    logic [7:0] pixel_dataout;
    logic       pixel_finish;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          fin_cyc = -1;
    logic [15:0] exp_q[$];
    int          wr_cyc[$];

    sti_dac_pixel_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .so_data      (so_data),
        .so_valid     (so_valid),
        .pi_end       (pi_end),
        .pixel_wr     (pixel_wr),
        .pixel_addr   (pixel_addr),
        .pixel_dataout(pixel_dataout),
        .pixel_finish (pixel_finish)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reset) begin
            if (pixel_wr) begin
                wr_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("spurious_wr", {31'd0, pixel_wr}, 32'd0);
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    check("wr_addr", {24'd0, pixel_addr}, {24'd0, e[15:8]});
                    check("wr_data", {24'd0, pixel_dataout}, {24'd0, e[7:0]});
                end
            end
            if (pixel_finish && fin_cyc < 0) fin_cyc = cyc;
        end
    end

    task automatic do_reset();
        reset    = 1'b0;
        so_valid = 1'b0;
        so_data  = 1'b0;
        pi_end   = 1'b0;
        exp_q.delete();
        wr_cyc.delete();
        fin_cyc = -1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic send_bit(input logic b);
        so_valid = 1'b1;
        so_data  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        so_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic push_fill(input int from);
        for (int a = from; a <= 255; a++) exp_q.push_back({8'(a), 8'h00});
    endtask

    task automatic wait_finish(input int limit);
        for (int i = 0; i < limit && !pixel_finish; i++) @(negedge clk);
        #1;
        check("finish", {31'd0, pixel_finish}, 32'd1);
        check("queue_empty", exp_q.size(), 32'd0);
        if (wr_cyc.size() > 0)
            check("finish_latency", fin_cyc - wr_cyc[wr_cyc.size()-1], 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #3 do_reset();
        reset = 1'b0;
        #1;
        check("rst_wr", {31'd0, pixel_wr}, 32'd0);
        check("rst_addr", {24'd0, pixel_addr}, 32'd0);
        check("rst_data", {24'd0, pixel_dataout}, 32'd0);
        check("rst_finish", {31'd0, pixel_finish}, 32'd0);

        // Two bytes back to back, then end of stream and zero fill
        do_reset();
        exp_q.push_back({8'd0, 8'hA5});
        exp_q.push_back({8'd1, 8'h3C});
        push_fill(2);
        send_byte(8'hA5);
        send_byte(8'h3C);
        so_valid = 1'b0;
        pi_end   = 1'b1;
        wait_finish(400);
        check("two_byte_gap", wr_cyc[1] - wr_cyc[0], 32'd8);
        check("two_byte_count", wr_cyc.size(), 32'd256);

        // Full memory from the stream; extra bits must be ignored
        do_reset();
        for (int n = 0; n < 256; n++) exp_q.push_back({8'(n), 8'(n)});
        for (int n = 0; n < 256; n++) send_byte(8'(n));
        send_byte(8'hFF);
        send_byte(8'h55);
        idle(4);
        check("full_finish", {31'd0, pixel_finish}, 32'd1);
        check("full_count", wr_cyc.size(), 32'd256);
        check("full_queue", exp_q.size(), 32'd0);
        check("full_fin_lat", fin_cyc - wr_cyc[255], 32'd1);

        // Gapped so_valid, one bit every three cycles
        do_reset();
        begin
            int a8;
            exp_q.push_back({8'd0, 8'hFF});
            for (int i = 0; i < 8; i++) begin
                send_bit(1'b1);
                if (i < 7) idle(2);
            end
            a8 = cyc;
            idle(5);
            check("gap_count", wr_cyc.size(), 32'd1);
            if (wr_cyc.size() > 0) check("gap_latency", wr_cyc[0], a8);
            check("gap_queue", exp_q.size(), 32'd0);
        end

        // 11 bits then end of stream: partial byte handling
        do_reset();
        exp_q.push_back({8'd0, 8'h81});
`ifdef PARTIAL_FLUSH_EN
        exp_q.push_back({8'd1, 8'hA0});
        push_fill(2);
`else
        push_fill(1);
`endif
        send_byte(8'h81);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        so_valid = 1'b0;
        pi_end   = 1'b1;
        wait_finish(400);
        check("partial_count", wr_cyc.size(), 32'd256);

        // End of stream with no data at all
        do_reset();
        push_fill(0);
        pi_end = 1'b1;
        wait_finish(400);
        check("empty_count", wr_cyc.size(), 32'd256);

        // Reset in the middle of FILL, then a fresh stream
        do_reset();
        push_fill(0);
        pi_end = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #1;
            if (pixel_wr && pixel_addr == 8'd100) break;
        end
        check("fill_reached_100", {24'd0, pixel_addr}, 32'd100);
        reset = 1'b0;
        #1;
        check("abort_wr", {31'd0, pixel_wr}, 32'd0);
        check("abort_addr", {24'd0, pixel_addr}, 32'd0);
        check("abort_data", {24'd0, pixel_dataout}, 32'd0);
        check("abort_finish", {31'd0, pixel_finish}, 32'd0);
        do_reset();
        exp_q.push_back({8'd0, 8'h5A});
        send_byte(8'h5A);
        idle(4);
        check("restart_count", wr_cyc.size(), 32'd1);
        check("restart_queue", exp_q.size(), 32'd0);
        check("restart_finish", {31'd0, pixel_finish}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
